// File: rtl/monitor_nios2_processor_cpu_debug_pkg.sv
// Shared defaults and command payload type for the Nios II debug slave sysclk side.
package monitor_nios2_processor_cpu_debug_pkg;

  localparam int unsigned DEF_SR_WIDTH    = 38;
  localparam int unsigned DEF_IR_WIDTH    = 2;
  localparam int unsigned DEF_ACTION_BIT  = 34;
  localparam int unsigned DEF_FIFO_DEPTH  = 4;
  localparam int unsigned DEF_SYNC_STAGES = 2;

  // Command payload at default widths; parameterised users build their own ir_t.
  typedef struct packed {
    logic [DEF_IR_WIDTH-1:0] ir;
    logic [DEF_SR_WIDTH-1:0] jdo;
  } debug_cmd_t;

endpackage

// File: rtl/monitor_nios2_processor_cpu_debug_sync_edge.sv
// Synchronises a TCK-domain level into clk and flags its rising edge once armed.
module monitor_nios2_processor_cpu_debug_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic arm,
  input  logic d,
  output logic rise
);

  logic [STAGES-1:0] sync;
  logic              dly;

  // Delay flop always tracks the chain so a level held through arming never looks like an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync <= '0;
      dly  <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      dly  <= sync[STAGES-1];
    end
  end

  assign rise = arm & sync[STAGES-1] & ~dly;

endmodule

// File: rtl/monitor_nios2_processor_cpu_debug_cmd_bridge.sv
// Sysclk side of the JTAG debug slave: syncs update strobes, queues commands, pulses one-hot actions.
module monitor_nios2_processor_cpu_debug_cmd_bridge
  import monitor_nios2_processor_cpu_debug_pkg::*;
#(
  parameter int unsigned SR_WIDTH    = DEF_SR_WIDTH,
  parameter int unsigned IR_WIDTH    = DEF_IR_WIDTH,
  parameter int unsigned ACTION_BIT  = DEF_ACTION_BIT,
  parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [SR_WIDTH-1:0]             sr,
  input  logic [IR_WIDTH-1:0]             ir_in,
  input  logic                            vs_udr,
  input  logic                            vs_uir,
  input  logic                            cmd_ready,
  input  logic                            clear_overflow,
  output logic                            cmd_valid,
  output logic [IR_WIDTH-1:0]             cmd_ir,
  output logic [SR_WIDTH-1:0]             cmd_jdo,
  output logic [SR_WIDTH-1:0]             jdo,
  output logic [(2**IR_WIDTH)-1:0]        take_action,
  output logic [(2**IR_WIDTH)-1:0]        take_no_action,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            overflow
);

  localparam int unsigned NCH = 2**IR_WIDTH;
  localparam int unsigned PW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned AW  = $clog2(SYNC_STAGES + 2);

  typedef logic [IR_WIDTH-1:0] ir_t;
  typedef struct packed {
    ir_t                 ir;
    logic [SR_WIDTH-1:0] jdo;
  } cmd_t;

  logic [AW-1:0] arm_cnt;
  logic          armed;
  logic          udr_rise;
  logic          uir_rise;
  ir_t           ir_latched;
  cmd_t          mem [FIFO_DEPTH];
  cmd_t          head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic          full;
  logic          pop;
  logic          push;
  logic          drop;
  logic [PW-1:0] rd_next;
  logic [CW-1:0] count_next;
  cmd_t          push_cmd;
  cmd_t          head_next;

  // Arming counter: edges are only honoured once the sync and delay flops have settled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arm_cnt <= '0;
    end else if (arm_cnt != AW'(SYNC_STAGES + 1)) begin
      arm_cnt <= arm_cnt + AW'(1);
    end
  end

  assign armed = (arm_cnt == AW'(SYNC_STAGES + 1));

  monitor_nios2_processor_cpu_debug_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_udr (
    .clk     (clk),
    .reset_n (reset_n),
    .arm     (armed),
    .d       (vs_udr),
    .rise    (udr_rise)
  );

  monitor_nios2_processor_cpu_debug_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_uir (
    .clk     (clk),
    .reset_n (reset_n),
    .arm     (armed),
    .d       (vs_uir),
    .rise    (uir_rise)
  );

  // Queue control; the head register is preloaded with whatever will sit at rd_next.
  always_comb begin
    full          = (fifo_count == CW'(FIFO_DEPTH));
    pop           = cmd_valid & cmd_ready;
    push          = udr_rise & (~full | pop);
    drop          = udr_rise & full & ~pop;
    rd_next       = pop ? rd_ptr + PW'(1) : rd_ptr;
    count_next    = fifo_count + CW'(push) - CW'(pop);
    push_cmd.ir   = ir_latched;
    push_cmd.jdo  = sr;
    head_next     = (push && (wr_ptr == rd_next)) ? push_cmd : mem[rd_next];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir_latched     <= '0;
      jdo            <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_count     <= '0;
      cmd_valid      <= 1'b0;
      head           <= '0;
      take_action    <= '0;
      take_no_action <= '0;
      overflow       <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (uir_rise) begin
        ir_latched <= ir_in;
      end
      if (udr_rise) begin
        jdo <= sr;
      end
      if (push) begin
        mem[wr_ptr] <= push_cmd;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      rd_ptr         <= rd_next;
      fifo_count     <= count_next;
      cmd_valid      <= (count_next != '0);
      head           <= head_next;
      take_action    <= (pop &&  head.jdo[ACTION_BIT]) ? (NCH'(1) << head.ir) : '0;
      take_no_action <= (pop && !head.jdo[ACTION_BIT]) ? (NCH'(1) << head.ir) : '0;
      if (drop) begin
        overflow <= 1'b1;
      end else if (clear_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

  assign cmd_ir  = head.ir;
  assign cmd_jdo = head.jdo;

endmodule

// File: tb/tb_monitor_nios2_processor_cpu_debug_cmd_bridge.sv
// Randomised bench for the debug command bridge against a transaction-level queue model.
module tb_monitor_nios2_processor_cpu_debug_cmd_bridge;

  localparam int unsigned SR_W  = 38;
  localparam int unsigned IR_W  = 2;
  localparam int unsigned NCH   = 4;
  localparam int unsigned ACT   = 34;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned STG   = 2;
  localparam int unsigned CW    = 3;

  logic              clk;
  logic              reset_n;
  logic [SR_W-1:0]   sr;
  logic [IR_W-1:0]   ir_in;
  logic              vs_udr;
  logic              vs_uir;
  logic              cmd_ready;
  logic              clear_overflow;
  logic              cmd_valid;
  logic [IR_W-1:0]   cmd_ir;
  logic [SR_W-1:0]   cmd_jdo;
  logic [SR_W-1:0]   jdo;
  logic [NCH-1:0]    take_action;
  logic [NCH-1:0]    take_no_action;
  logic [CW-1:0]     fifo_count;
  logic              overflow;

  monitor_nios2_processor_cpu_debug_cmd_bridge #(
    .SR_WIDTH    (SR_W),
    .IR_WIDTH    (IR_W),
    .ACTION_BIT  (ACT),
    .FIFO_DEPTH  (DEPTH),
    .SYNC_STAGES (STG)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .sr             (sr),
    .ir_in          (ir_in),
    .vs_udr         (vs_udr),
    .vs_uir         (vs_uir),
    .cmd_ready      (cmd_ready),
    .clear_overflow (clear_overflow),
    .cmd_valid      (cmd_valid),
    .cmd_ir         (cmd_ir),
    .cmd_jdo        (cmd_jdo),
    .jdo            (jdo),
    .take_action    (take_action),
    .take_no_action (take_no_action),
    .fifo_count     (fifo_count),
    .overflow       (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of {ir, sr} commands plus the visible side state.
  logic [IR_W+SR_W-1:0] q [$];
  logic [SR_W-1:0]      jdo_m;
  logic [IR_W-1:0]      ir_m;
  logic                 ovf_m;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    jdo_m = '0;
    ir_m  = '0;
    ovf_m = 1'b0;
  endtask

  task automatic model_push(input logic [SR_W-1:0] v);
    jdo_m = v;
    if (q.size() < DEPTH) q.push_back({ir_m, v});
    else ovf_m = 1'b1;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_count"}, 64'(fifo_count), 64'(q.size()));
    check({tag, "_valid"}, 64'(cmd_valid), 64'(q.size() != 0));
    check({tag, "_ovf"},   64'(overflow),  64'(ovf_m));
    check({tag, "_jdo"},   64'(jdo),       64'(jdo_m));
  endtask

  task automatic uir_pulse(input logic [IR_W-1:0] v);
    ir_in  = v;
    vs_uir = 1'b1;
    repeat (STG + 1) @(negedge clk);
    vs_uir = 1'b0;
    repeat (STG + 1) @(negedge clk);
    ir_m = v;
  endtask

  task automatic udr_pulse(input logic [SR_W-1:0] v);
    sr     = v;
    vs_udr = 1'b1;
    repeat (STG + 1) @(negedge clk);
    vs_udr = 1'b0;
    repeat (STG + 1) @(negedge clk);
    model_push(v);
  endtask

  task automatic expect_take(input string tag, input logic [IR_W+SR_W-1:0] h);
    logic [NCH-1:0] oh;
    oh = NCH'(1) << h[IR_W+SR_W-1:SR_W];
    check({tag, "_act"},  64'(take_action),    64'(h[ACT] ? oh : '0));
    check({tag, "_nact"}, 64'(take_no_action), 64'(h[ACT] ? '0 : oh));
  endtask

  task automatic pop_one(input string tag);
    logic [IR_W+SR_W-1:0] h;
    if (q.size() == 0) begin
      check({tag, "_empty_valid"}, 64'(cmd_valid), 64'(0));
      cmd_ready = 1'b1;
      @(negedge clk);
      cmd_ready = 1'b0;
      check({tag, "_empty_take"}, 64'({take_action, take_no_action}), 64'(0));
    end else begin
      h = q.pop_front();
      check({tag, "_valid"}, 64'(cmd_valid), 64'(1));
      check({tag, "_ir"},    64'(cmd_ir),    64'(h[IR_W+SR_W-1:SR_W]));
      check({tag, "_data"},  64'(cmd_jdo),   64'(h[SR_W-1:0]));
      cmd_ready = 1'b1;
      @(negedge clk);
      cmd_ready = 1'b0;
      expect_take(tag, h);
      check({tag, "_count"}, 64'(fifo_count), 64'(q.size()));
      @(negedge clk);
      check({tag, "_take_end"}, 64'({take_action, take_no_action}), 64'(0));
    end
  endtask

  task automatic clear_ovf();
    clear_overflow = 1'b1;
    @(negedge clk);
    clear_overflow = 1'b0;
    ovf_m = 1'b0;
    check("clear_ovf", 64'(overflow), 64'(0));
  endtask

  logic [63:0]          r64;
  logic [SR_W-1:0]      v;
  logic [IR_W+SR_W-1:0] hh;

  initial begin
    reset_n = 1'b0; vs_udr = 1'b1; vs_uir = 1'b0; sr = '0; ir_in = '0;
    cmd_ready = 1'b0; clear_overflow = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_state("rst");
    check("rst_cmd_ir",  64'(cmd_ir),  64'(0));
    check("rst_cmd_jdo", 64'(cmd_jdo), 64'(0));
    check("rst_take",    64'({take_action, take_no_action}), 64'(0));

    // Level already high at release must not be seen as an update.
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check_state("arm_high");
    vs_udr = 1'b0;
    repeat (STG + 2) @(negedge clk);
    check_state("arm_fall");

    // Directed latency and action decode.
    uir_pulse(2'd2);
    sr = 38'h04_0000_1234;
    vs_udr = 1'b1;
    repeat (STG) @(negedge clk);
    check("lat_early", 64'(cmd_valid), 64'(0));
    @(negedge clk);
    check("lat_valid", 64'(cmd_valid), 64'(1));
    model_push(38'h04_0000_1234);
    vs_udr = 1'b0;
    repeat (STG + 1) @(negedge clk);
    check_state("dir1");
    pop_one("dir1_pop");

    // Overflow: five updates into a four-deep queue.
    for (int i = 0; i < 5; i++) begin
      r64 = {$urandom, $urandom};
      udr_pulse(SR_W'(r64));
    end
    check_state("ovf");
    while (q.size() > 0) pop_one("ovf_drain");
    check_state("ovf_empty");
    clear_ovf();

    // Full queue with a push and pop on the same edge.
    for (int i = 0; i < 4; i++) begin
      r64 = {$urandom, $urandom};
      udr_pulse(SR_W'(r64));
    end
    r64 = {$urandom, $urandom};
    v = SR_W'(r64);
    sr = v;
    vs_udr = 1'b1;
    repeat (STG) @(negedge clk);
    hh = q.pop_front();
    check("simul_head", 64'(cmd_jdo), 64'(hh[SR_W-1:0]));
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    q.push_back({ir_m, v});
    jdo_m = v;
    expect_take("simul", hh);
    check_state("simul");
    vs_udr = 1'b0;
    repeat (STG + 1) @(negedge clk);
    while (q.size() > 0) pop_one("simul_drain");

    // No-action decode on channel 1.
    uir_pulse(2'd1);
    udr_pulse(38'h00_1234_5678);
    pop_one("noact");
    pop_one("noact_empty");

    // Random mix of updates, pops and overflow clears.
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: uir_pulse(IR_W'($urandom));
        1: begin
          r64 = {$urandom, $urandom};
          udr_pulse(SR_W'(r64));
          check_state("rnd_udr");
        end
        2: pop_one("rnd_pop");
        default: clear_ovf();
      endcase
    end
    while (q.size() > 0) pop_one("rnd_drain");

    // Reset mid-operation with commands queued and an update in flight.
    clear_ovf();
    udr_pulse(38'h3F_FFFF_FFFF);
    udr_pulse(38'h00_0000_0001);
    sr = 38'h15_5555_5555;
    vs_udr = 1'b1;
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    repeat (10) @(negedge clk);
    check_state("rst2");
    check("rst2_take", 64'({take_action, take_no_action}), 64'(0));
    vs_udr = 1'b0;
    repeat (STG + 2) @(negedge clk);
    check_state("rst2_fall");
    pop_one("rst2_pop");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
